axi_interconnect_nto1: RTL and testbench
========================================

AXI_INTERCONNECT_NTO1 -- requirements
Module: axi_interconnect_nto1

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of upstream masters (2..8).
REQ-002 SHALL have parameter ID_WIDTH, default 4, upstream ID width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 48; DATA_WIDTH, default 256; STRB_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter WFIFO_DEPTH, default 4, number of outstanding AW grants awaiting W data (power of 2, >=2).
REQ-005 SHALL define PW = clog2(NUM_SLAVES) and MID_WIDTH = ID_WIDTH+PW.
REQ-006 SHALL use one clock and a synchronous active-high reset.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 s_aw{id,addr,len,size,burst,lock,cache,prot,qos}  in  N x field  per-port AW payload, flattened, port i at [i*W +: W].
REQ-010 s_awvalid in N, s_awready out N; s_ar* mirror the AW payload, valid and ready set.
REQ-011 s_wdata in N*DATA_WIDTH; s_wstrb in N*STRB_WIDTH; s_wlast, s_wvalid in N; s_wready out N.
REQ-012 s_bid out N*ID_WIDTH; s_bresp out N*2; s_bvalid out N; s_bready in N.
REQ-013 s_rid out N*ID_WIDTH; s_rdata out N*DATA_WIDTH; s_rresp out N*2; s_rlast, s_rvalid out N; s_rready in N.
REQ-014 m_aw*/m_ar* out: single-width payload with m_awid/m_arid MID_WIDTH wide; m_awvalid/m_arvalid out 1; m_awready/m_arready in 1.
REQ-015 m_wdata, m_wstrb, m_wlast, m_wvalid out; m_wready in.
REQ-016 m_bid in MID_WIDTH; m_bresp, m_bvalid in; m_bready out.
REQ-017 m_rid in MID_WIDTH; m_rdata, m_rresp, m_rlast, m_rvalid in; m_rready out.

Function
REQ-018 AW and AR SHALL each use an independent round-robin arbiter. The port after the last accepted port has highest priority. The pointer SHALL advance only on an m_*valid & m_*ready handshake.
REQ-019 Arbiter states SHALL be IDLE and LOCKED. LOCKED is entered when a grant is issued and m_*ready=0. The grant SHALL hold, with payload stable, until the handshake, and then return to IDLE.
REQ-020 A grant SHALL be issued in the same cycle as the request (zero-latency pass-through). s_*ready[i] = grant[i] & m_*ready.
REQ-021 Downstream ID SHALL be m_awid = {port index, s_awid[i]}; m_arid is formed the same way.
REQ-022 Each AW handshake SHALL push the granted port index into the W-order FIFO.
REQ-023 AW grant SHALL be suppressed (m_awvalid=0) while the FIFO holds WFIFO_DEPTH entries, even if a pop occurs in the same cycle.
REQ-024 W SHALL forward from the port at the FIFO head only: m_w* = s_w*[head]; m_wvalid = !empty & s_wvalid[head]; s_wready[head] = !empty & m_wready; all other s_wready = 0.
REQ-025 The FIFO SHALL pop on a W handshake with m_wlast=1. Simultaneous push and pop SHALL keep the count unchanged.
REQ-026 When the FIFO is empty, m_wvalid=0 and all s_wready=0. W beats arriving before their AW SHALL wait.
REQ-027 B routing: port p = m_bid[MID_WIDTH-1:ID_WIDTH]. s_bvalid[p] = m_bvalid; s_bid[p] = m_bid[ID_WIDTH-1:0]; m_bready = s_bready[p].
REQ-028 R routing SHALL work the same way on m_rid, with s_rlast[p] = m_rlast.
REQ-029 A response with p >= NUM_SLAVES SHALL be accepted and dropped (m_bready/m_rready = 1, no s_*valid asserted).
REQ-030 The block SHALL add no response buffering: B and R are combinational with zero latency.

Reset
REQ-031 While rst=1, all m_*valid, s_*ready, s_*valid and m_bready/m_rready SHALL be 0.
REQ-032 Reset SHALL set both RR pointers to port 0, both arbiters to IDLE, and the FIFO to empty with pointers and count at 0.
REQ-033 Reset asserted mid-burst SHALL discard in-flight W-order state. After rst falls, the first grant SHALL behave as in REQ-032.

Verification
REQ-034 N=4, ports 0..3 raise AWVALID together with m_awready=1 -> grants in order 0,1,2,3, one per cycle, m_awid[5:4] = 0,1,2,3.
REQ-035 Port 2 requests AW with m_awready=0 for 5 cycles while port 0 raises valid -> grant stays on 2 with stable payload; port 0 is granted the cycle after the handshake.
REQ-036 WFIFO_DEPTH=4, five AW accepted from ports 1,3,1,0,2 with W held off -> fifth AW blocked (m_awvalid=0). Then W bursts (len=3) complete in order 1,3,1,0, and AW from port 2 is accepted after the first wlast.
REQ-037 Port 3 presents W before its AW -> s_wready[3]=0 until its AW handshake, then beats flow with zero added latency.
REQ-038 m_bvalid=1 with m_bid=6'b10_0101 -> s_bvalid[2]=1, s_bid[2]=4'h5, m_bready follows s_bready[2]. m_rid=6'b11_xxxx, rlast=1 -> routed to port 3 only.
REQ-039 rst pulsed for 1 cycle with 2 FIFO entries and a LOCKED AR -> all valids/readies are 0 in the next cycle, FIFO is empty, and the next AR grant goes to the lowest requesting port.

Source files
------------

// File: rtl/axi_interconnect_nto1.sv
// N-to-1 AXI interconnect: independent round-robin AW/AR arbiters with zero-latency pass-through,
// W steered by an AW-order FIFO, B/R routed back by the port index carried in the upper ID bits.

module axi_interconnect_nto1_rr_arb #(
   parameter int N    = 4,
   parameter int PW   = 2,
   parameter int PAYW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req,
   input  logic [N*PAYW-1:0] payload,
   input  logic              block,
   input  logic              m_ready,
   output logic              m_valid,
   output logic [PAYW-1:0]   m_payload,
   output logic [PW-1:0]     grant_idx,
   output logic [N-1:0]      s_ready
);
   typedef enum logic {IDLE, LOCKED} arb_state_t;

   arb_state_t    state_reg, state_next;
   logic [PW-1:0] rr_ptr_reg, rr_ptr_next;
   logic [PW-1:0] lock_idx_reg, lock_idx_next;
   logic [PW-1:0] pick_idx, cand_idx;
   logic          pick_found;

   // First requester at or after the pointer, wrapping around.
   always_comb begin
      pick_idx   = '0;
      pick_found = 1'b0;
      cand_idx   = '0;
      for (int k = 0; k < N; k++) begin
         cand_idx = PW'((int'(rr_ptr_reg) + k) % N);
         if (!pick_found && req[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      rr_ptr_next   = rr_ptr_reg;
      lock_idx_next = lock_idx_reg;
      grant_idx     = pick_idx;
      m_valid       = 1'b0;
      case (state_reg)
         IDLE: begin
            m_valid = pick_found & ~block;
            if (m_valid) begin
               if (m_ready) begin
                  rr_ptr_next = PW'((int'(pick_idx) + 1) % N);
               end else begin
                  state_next    = LOCKED;
                  lock_idx_next = pick_idx;
               end
            end
         end
         LOCKED: begin
            grant_idx = lock_idx_reg;
            m_valid   = req[lock_idx_reg];
            if (m_valid && m_ready) begin
               state_next  = IDLE;
               rr_ptr_next = PW'((int'(lock_idx_reg) + 1) % N);
            end
         end
         default: state_next = IDLE;
      endcase
      if (rst) m_valid = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= '0;
         lock_idx_reg <= '0;
      end else begin
         state_reg    <= state_next;
         rr_ptr_reg   <= rr_ptr_next;
         lock_idx_reg <= lock_idx_next;
      end
   end

   assign m_payload = payload[grant_idx*PAYW +: PAYW];

   for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign s_ready[gi] = m_valid & m_ready & (grant_idx == PW'(gi));
   end
endmodule

module axi_interconnect_nto1 #(
   parameter int NUM_SLAVES  = 4,
   parameter int ID_WIDTH    = 4,
   parameter int ADDR_WIDTH  = 48,
   parameter int DATA_WIDTH  = 256,
   parameter int STRB_WIDTH  = DATA_WIDTH/8,
   parameter int WFIFO_DEPTH = 4,
   localparam int PW         = $clog2(NUM_SLAVES),
   localparam int MID_WIDTH  = ID_WIDTH + PW
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_SLAVES*ID_WIDTH-1:0]   s_awid,
   input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_awaddr,
   input  logic [NUM_SLAVES*8-1:0]          s_awlen,
   input  logic [NUM_SLAVES*3-1:0]          s_awsize,
   input  logic [NUM_SLAVES*2-1:0]          s_awburst,
   input  logic [NUM_SLAVES-1:0]            s_awlock,
   input  logic [NUM_SLAVES*4-1:0]          s_awcache,
   input  logic [NUM_SLAVES*3-1:0]          s_awprot,
   input  logic [NUM_SLAVES*4-1:0]          s_awqos,
   input  logic [NUM_SLAVES-1:0]            s_awvalid,
   output logic [NUM_SLAVES-1:0]            s_awready,
   input  logic [NUM_SLAVES*ID_WIDTH-1:0]   s_arid,
   input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_araddr,
   input  logic [NUM_SLAVES*8-1:0]          s_arlen,
   input  logic [NUM_SLAVES*3-1:0]          s_arsize,
   input  logic [NUM_SLAVES*2-1:0]          s_arburst,
   input  logic [NUM_SLAVES-1:0]            s_arlock,
   input  logic [NUM_SLAVES*4-1:0]          s_arcache,
   input  logic [NUM_SLAVES*3-1:0]          s_arprot,
   input  logic [NUM_SLAVES*4-1:0]          s_arqos,
   input  logic [NUM_SLAVES-1:0]            s_arvalid,
   output logic [NUM_SLAVES-1:0]            s_arready,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_wdata,
   input  logic [NUM_SLAVES*STRB_WIDTH-1:0] s_wstrb,
   input  logic [NUM_SLAVES-1:0]            s_wlast,
   input  logic [NUM_SLAVES-1:0]            s_wvalid,
   output logic [NUM_SLAVES-1:0]            s_wready,
   output logic [NUM_SLAVES*ID_WIDTH-1:0]   s_bid,
   output logic [NUM_SLAVES*2-1:0]          s_bresp,
   output logic [NUM_SLAVES-1:0]            s_bvalid,
   input  logic [NUM_SLAVES-1:0]            s_bready,
   output logic [NUM_SLAVES*ID_WIDTH-1:0]   s_rid,
   output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
   output logic [NUM_SLAVES*2-1:0]          s_rresp,
   output logic [NUM_SLAVES-1:0]            s_rlast,
   output logic [NUM_SLAVES-1:0]            s_rvalid,
   input  logic [NUM_SLAVES-1:0]            s_rready,
   output logic [MID_WIDTH-1:0]             m_awid,
   output logic [ADDR_WIDTH-1:0]            m_awaddr,
   output logic [7:0]                       m_awlen,
   output logic [2:0]                       m_awsize,
   output logic [1:0]                       m_awburst,
   output logic                             m_awlock,
   output logic [3:0]                       m_awcache,
   output logic [2:0]                       m_awprot,
   output logic [3:0]                       m_awqos,
   output logic                             m_awvalid,
   input  logic                             m_awready,
   output logic [MID_WIDTH-1:0]             m_arid,
   output logic [ADDR_WIDTH-1:0]            m_araddr,
   output logic [7:0]                       m_arlen,
   output logic [2:0]                       m_arsize,
   output logic [1:0]                       m_arburst,
   output logic                             m_arlock,
   output logic [3:0]                       m_arcache,
   output logic [2:0]                       m_arprot,
   output logic [3:0]                       m_arqos,
   output logic                             m_arvalid,
   input  logic                             m_arready,
   output logic [DATA_WIDTH-1:0]            m_wdata,
   output logic [STRB_WIDTH-1:0]            m_wstrb,
   output logic                             m_wlast,
   output logic                             m_wvalid,
   input  logic                             m_wready,
   input  logic [MID_WIDTH-1:0]             m_bid,
   input  logic [1:0]                       m_bresp,
   input  logic                             m_bvalid,
   output logic                             m_bready,
   input  logic [MID_WIDTH-1:0]             m_rid,
   input  logic [DATA_WIDTH-1:0]            m_rdata,
   input  logic [1:0]                       m_rresp,
   input  logic                             m_rlast,
   input  logic                             m_rvalid,
   output logic                             m_rready
);
   localparam int AXW = ID_WIDTH + ADDR_WIDTH + 25;
   localparam int FAW = $clog2(WFIFO_DEPTH);

   logic [NUM_SLAVES*AXW-1:0] aw_pay, ar_pay;
   logic [AXW-1:0]            aw_m_pay, ar_m_pay;
   logic [PW-1:0]             aw_idx, ar_idx;
   logic [ID_WIDTH-1:0]       aw_id_low, ar_id_low;

   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_pack
      assign aw_pay[gi*AXW +: AXW] = {s_awid[gi*ID_WIDTH +: ID_WIDTH], s_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH],
         s_awlen[gi*8 +: 8], s_awsize[gi*3 +: 3], s_awburst[gi*2 +: 2], s_awlock[gi],
         s_awcache[gi*4 +: 4], s_awprot[gi*3 +: 3], s_awqos[gi*4 +: 4]};
      assign ar_pay[gi*AXW +: AXW] = {s_arid[gi*ID_WIDTH +: ID_WIDTH], s_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH],
         s_arlen[gi*8 +: 8], s_arsize[gi*3 +: 3], s_arburst[gi*2 +: 2], s_arlock[gi],
         s_arcache[gi*4 +: 4], s_arprot[gi*3 +: 3], s_arqos[gi*4 +: 4]};
   end

   // W-order FIFO: one port index per accepted AW, popped on the last W beat.
   logic [PW-1:0]  wfifo_mem [WFIFO_DEPTH];
   logic [FAW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [FAW:0]   count_reg;
   logic           wfifo_full, wfifo_empty, push, pop, w_active;
   logic [PW-1:0]  w_head;

   assign wfifo_full  = (count_reg == (FAW+1)'(WFIFO_DEPTH));
   assign wfifo_empty = (count_reg == '0);
   assign push        = m_awvalid & m_awready;
   assign pop         = m_wvalid & m_wready & m_wlast;

   axi_interconnect_nto1_rr_arb #(.N(NUM_SLAVES), .PW(PW), .PAYW(AXW)) u_aw_arb (
      .clk(clk), .rst(rst), .req(s_awvalid), .payload(aw_pay), .block(wfifo_full),
      .m_ready(m_awready), .m_valid(m_awvalid), .m_payload(aw_m_pay), .grant_idx(aw_idx),
      .s_ready(s_awready)
   );

   axi_interconnect_nto1_rr_arb #(.N(NUM_SLAVES), .PW(PW), .PAYW(AXW)) u_ar_arb (
      .clk(clk), .rst(rst), .req(s_arvalid), .payload(ar_pay), .block(1'b0),
      .m_ready(m_arready), .m_valid(m_arvalid), .m_payload(ar_m_pay), .grant_idx(ar_idx),
      .s_ready(s_arready)
   );

   assign {aw_id_low, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos} = aw_m_pay;
   assign {ar_id_low, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos} = ar_m_pay;
   assign m_awid = {aw_idx, aw_id_low};
   assign m_arid = {ar_idx, ar_id_low};

   always_ff @(posedge clk) begin
      if (push) wfifo_mem[wr_ptr_reg] <= aw_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + FAW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + FAW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (FAW+1)'(1);
            2'b01:   count_reg <= count_reg - (FAW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign w_head   = wfifo_mem[rd_ptr_reg];
   assign w_active = ~rst & ~wfifo_empty;
   assign m_wdata  = s_wdata[w_head*DATA_WIDTH +: DATA_WIDTH];
   assign m_wstrb  = s_wstrb[w_head*STRB_WIDTH +: STRB_WIDTH];
   assign m_wlast  = s_wlast[w_head];
   assign m_wvalid = w_active & s_wvalid[w_head];

   // Responses carry their return port in the ID bits above the upstream ID.
   logic [PW-1:0] b_port, r_port;
   logic          b_hit, r_hit;

   assign b_port   = m_bid[MID_WIDTH-1:ID_WIDTH];
   assign r_port   = m_rid[MID_WIDTH-1:ID_WIDTH];
   assign b_hit    = (int'(b_port) < NUM_SLAVES);
   assign r_hit    = (int'(r_port) < NUM_SLAVES);
   assign m_bready = ~rst & (b_hit ? s_bready[b_port] : 1'b1);
   assign m_rready = ~rst & (r_hit ? s_rready[r_port] : 1'b1);

   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_route
      assign s_wready[gi]                         = w_active & m_wready & (w_head == PW'(gi));
      assign s_bvalid[gi]                         = ~rst & m_bvalid & (b_port == PW'(gi));
      assign s_bid[gi*ID_WIDTH +: ID_WIDTH]       = m_bid[ID_WIDTH-1:0];
      assign s_bresp[gi*2 +: 2]                   = m_bresp;
      assign s_rvalid[gi]                         = ~rst & m_rvalid & (r_port == PW'(gi));
      assign s_rlast[gi]                          = m_rlast & (r_port == PW'(gi));
      assign s_rid[gi*ID_WIDTH +: ID_WIDTH]       = m_rid[ID_WIDTH-1:0];
      assign s_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = m_rdata;
      assign s_rresp[gi*2 +: 2]                   = m_rresp;
   end
endmodule

// File: tb/tb_axi_interconnect_nto1.sv
// Scoreboard bench for axi_interconnect_nto1: expected AW grants and W beats are queued at stimulus
// time and popped by a monitor as the DUT hands them off downstream.

module tb_axi_interconnect_nto1;
   localparam int N = 4, IDW = 4, AW = 48, DW = 32, SW = 4, MW = 6;

   logic clk = 1'b0, rst = 1'b1;
   logic [N*IDW-1:0] s_awid, s_arid, s_bid, s_rid;
   logic [N*AW-1:0]  s_awaddr, s_araddr;
   logic [N*8-1:0]   s_awlen, s_arlen;
   logic [N*3-1:0]   s_awsize, s_arsize, s_awprot, s_arprot;
   logic [N*2-1:0]   s_awburst, s_arburst, s_bresp, s_rresp;
   logic [N-1:0]     s_awlock, s_arlock, s_awvalid, s_awready, s_arvalid, s_arready;
   logic [N*4-1:0]   s_awcache, s_arcache, s_awqos, s_arqos;
   logic [N*DW-1:0]  s_wdata, s_rdata;
   logic [N*SW-1:0]  s_wstrb;
   logic [N-1:0]     s_wlast, s_wvalid, s_wready, s_bvalid, s_bready, s_rlast, s_rvalid, s_rready;
   logic [MW-1:0]    m_awid, m_arid, m_bid, m_rid;
   logic [AW-1:0]    m_awaddr, m_araddr;
   logic [7:0]       m_awlen, m_arlen;
   logic [2:0]       m_awsize, m_arsize, m_awprot, m_arprot;
   logic [1:0]       m_awburst, m_arburst, m_bresp, m_rresp;
   logic             m_awlock, m_arlock, m_awvalid, m_awready, m_arvalid, m_arready;
   logic [3:0]       m_awcache, m_arcache, m_awqos, m_arqos;
   logic [DW-1:0]    m_wdata, m_rdata;
   logic [SW-1:0]    m_wstrb;
   logic             m_wlast, m_wvalid, m_wready, m_bvalid, m_bready, m_rlast, m_rvalid, m_rready;

   int checks = 0, errors = 0;
   logic [21:0] aw_exp_q[$];
   logic [32:0] w_exp_q[$];
   logic [21:0] aw_e;
   logic [32:0] w_e;
   logic [32:0] wbuf [N][8];
   int wrd [N];
   int wwr [N];
   int aw_first_cyc [N];
   int first_wlast_cyc;
   int n;

   axi_interconnect_nto1 #(.NUM_SLAVES(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                           .WFIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot), .s_awqos(s_awqos),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot), .s_arqos(s_arqos),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
      .s_rready(s_rready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
      .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
      .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
      .m_rready(m_rready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: every downstream AW / W handshake is compared against the head of its scoreboard.
   always @(negedge clk) begin
      if (!rst && m_awvalid && m_awready) begin
         $display("aw: id %0h addr %0h len %0d", m_awid, m_awaddr, m_awlen);
         if (aw_exp_q.size() == 0) check("aw_unexpected", 1, 0);
         else begin
            aw_e = aw_exp_q.pop_front();
            check("aw_grant", {m_awid, m_awaddr[15:0]}, aw_e);
         end
      end
      if (!rst && m_wvalid && m_wready) begin
         $display("w: data %h last %b strb %h", m_wdata, m_wlast, m_wstrb);
         if (w_exp_q.size() == 0) check("w_unexpected", 1, 0);
         else begin
            w_e = w_exp_q.pop_front();
            check("w_beat", {m_wlast, m_wdata}, w_e);
         end
      end
   end

   task automatic clear_inputs();
      {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos, s_awvalid} = '0;
      {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arqos, s_arvalid} = '0;
      {s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready, s_rready} = '0;
      {m_awready, m_arready, m_wready, m_bid, m_bresp, m_bvalid} = '0;
      {m_rid, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      aw_exp_q.delete();
      w_exp_q.delete();
      for (int p = 0; p < N; p++) begin wrd[p] = 0; wwr[p] = 0; end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic aw_req(input int p, input logic [3:0] id, input logic [15:0] addr);
      s_awid[p*IDW +: IDW] = id;
      s_awaddr[p*AW +: AW] = {32'h0, addr};
      s_awlen[p*8 +: 8]    = 8'd3;
      s_awvalid[p]         = 1'b1;
      aw_exp_q.push_back({2'(p), id, addr});
   endtask

   task automatic ar_req(input int p, input logic [3:0] id);
      s_arid[p*IDW +: IDW] = id;
      s_araddr[p*AW +: AW] = 48'(p) << 8;
      s_arvalid[p]         = 1'b1;
   endtask

   task automatic w_burst(input int p, input int tag, input int beats);
      logic [32:0] beat;
      for (int b = 0; b < beats; b++) begin
         beat = {(b == beats - 1), 8'(p), 8'(tag), 8'(b), 8'hA5};
         wbuf[p][wwr[p]] = beat;
         wwr[p]++;
         w_exp_q.push_back(beat);
      end
   endtask

   task automatic apply_w();
      for (int p = 0; p < N; p++) begin
         s_wvalid[p] = (wrd[p] < wwr[p]);
         s_wstrb[p*SW +: SW] = 4'hF;
         if (wrd[p] < wwr[p]) {s_wlast[p], s_wdata[p*DW +: DW]} = wbuf[p][wrd[p]];
      end
   endtask

   function automatic logic w_pending();
      logic any = 1'b0;
      for (int p = 0; p < N; p++) if (wrd[p] < wwr[p]) any = 1'b1;
      return any;
   endfunction

   // Drives queued AW/W until everything has handed off; records handshake cycles.
   task automatic run_traffic(input int budget, output int cyc);
      logic [N-1:0] aw_hs, w_hs;
      cyc = 0;
      first_wlast_cyc = -1;
      for (int p = 0; p < N; p++) aw_first_cyc[p] = -1;
      while ((s_awvalid != 0 || w_pending()) && cyc < budget) begin
         apply_w();
         @(negedge clk);
         aw_hs = s_awvalid & s_awready;
         w_hs  = s_wvalid & s_wready;
         if (w_hs != 0 && m_wlast && first_wlast_cyc < 0) first_wlast_cyc = cyc;
         for (int p = 0; p < N; p++) if (aw_hs[p] && aw_first_cyc[p] < 0) aw_first_cyc[p] = cyc;
         @(posedge clk); #1;
         s_awvalid = s_awvalid & ~aw_hs;
         for (int p = 0; p < N; p++) if (w_hs[p]) wrd[p]++;
         cyc++;
      end
      apply_w();
      if (s_awvalid != 0 || w_pending()) check("traffic_timeout", {s_awvalid, 3'b0, w_pending()}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      // Reset state with every input active.
      clear_inputs();
      s_awvalid = 4'hF; s_arvalid = 4'hF; s_wvalid = 4'hF; s_bready = 4'hF; s_rready = 4'hF;
      m_awready = 1'b1; m_arready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_rvalid = 1'b1;
      @(negedge clk);
      check("rst_m_awvalid", m_awvalid, 0);
      check("rst_m_arvalid", m_arvalid, 0);
      check("rst_m_wvalid", m_wvalid, 0);
      check("rst_s_readies", {s_awready, s_arready, s_wready}, 0);
      check("rst_s_valids", {s_bvalid, s_rvalid}, 0);
      check("rst_m_bready_rready", {m_bready, m_rready}, 0);

      // Simultaneous requests: grants 0,1,2,3 one per cycle.
      do_reset();
      m_awready = 1'b1;
      for (int p = 0; p < N; p++) aw_req(p, 4'(p + 8), 16'(p * 16'h40));
      run_traffic(10, n);
      check("rr_cycles", n, 4);
      for (int p = 0; p < N; p++) check("rr_order", aw_first_cyc[p], p);

      // Backpressured grant holds on port 2; port 0 goes next.
      do_reset();
      aw_req(2, 4'h3, 16'h0200);
      @(posedge clk); #1;
      aw_req(0, 4'h4, 16'h0300);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("lock_valid", m_awvalid, 1);
         check("lock_payload", {m_awid, m_awaddr}, {6'h23, 48'h0200});
         check("lock_sready", s_awready, 0);
         @(posedge clk); #1;
      end
      m_awready = 1'b1;
      run_traffic(10, n);
      check("lock_port2_cyc", aw_first_cyc[2], 0);
      check("lock_port0_cyc", aw_first_cyc[0], 1);

      // FIFO full blocks the fifth AW until the first burst completes.
      do_reset();
      m_awready = 1'b1; m_wready = 1'b1;
      aw_req(1, 4'h1, 16'h1100); run_traffic(5, n);
      aw_req(3, 4'h3, 16'h1300); run_traffic(5, n);
      aw_req(1, 4'h2, 16'h1110); run_traffic(5, n);
      aw_req(0, 4'h0, 16'h1000); run_traffic(5, n);
      aw_req(2, 4'h6, 16'h1200);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("full_awvalid", m_awvalid, 0);
         check("full_awready2", s_awready[2], 0);
         @(posedge clk); #1;
      end
      w_burst(1, 0, 4); w_burst(3, 0, 4); w_burst(1, 1, 4); w_burst(0, 0, 4); w_burst(2, 0, 4);
      run_traffic(60, n);
      check("full_first_wlast", first_wlast_cyc, 3);
      check("full_aw2_cyc", aw_first_cyc[2], 4);
      check("full_total_cyc", n, 20);
      check("full_w_left", w_exp_q.size(), 0);
      check("full_aw_left", aw_exp_q.size(), 0);

      // W ahead of AW on port 3 waits, then flows with no gap.
      do_reset();
      m_awready = 1'b1; m_wready = 1'b1;
      w_burst(3, 5, 2);
      apply_w();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("early_w_wready", s_wready[3], 0);
         check("early_w_mvalid", m_wvalid, 0);
         @(posedge clk); #1;
      end
      aw_req(3, 4'h9, 16'h0700);
      @(negedge clk);
      check("early_aw_ready", s_awready[3], 1);
      check("early_w_same_cyc", s_wready[3], 0);
      @(posedge clk); #1;
      s_awvalid[3] = 1'b0;
      @(negedge clk);
      check("early_w_beat0", s_wready[3], 1);
      @(posedge clk); #1;
      wrd[3]++; apply_w();
      @(negedge clk);
      check("early_w_beat1", {s_wready[3], m_wlast}, 2'b11);
      @(posedge clk); #1;
      wrd[3]++; apply_w();
      check("early_w_left", w_exp_q.size(), 0);

      // B and R routing by upper ID bits.
      do_reset();
      m_bvalid = 1'b1; m_bid = 6'b10_0101; m_bresp = 2'b10; s_bready = 4'b0100;
      @(negedge clk);
      check("b_valid", s_bvalid, 4'b0100);
      check("b_id", s_bid[8 +: 4], 4'h5);
      check("b_resp", s_bresp[4 +: 2], 2'b10);
      check("b_ready_hi", m_bready, 1);
      @(posedge clk); #1;
      s_bready = 4'b1011;
      @(negedge clk);
      check("b_ready_lo", m_bready, 0);
      @(posedge clk); #1;
      m_bvalid = 1'b0;
      m_rvalid = 1'b1; m_rid = 6'b11_1010; m_rlast = 1'b1; m_rdata = 32'hCAFE_F00D; s_rready = 4'b1000;
      @(negedge clk);
      check("r_valid", s_rvalid, 4'b1000);
      check("r_last", s_rlast, 4'b1000);
      check("r_id", s_rid[12 +: 4], 4'hA);
      check("r_data", s_rdata[96 +: 32], 32'hCAFE_F00D);
      check("r_ready_hi", m_rready, 1);
      check("b_idle", s_bvalid, 0);
      @(posedge clk); #1;
      m_rid = 6'b00_0011;
      @(negedge clk);
      check("r_valid_p0", s_rvalid, 4'b0001);
      check("r_ready_p0", m_rready, 0);

      // Mid-flight reset with two FIFO entries and a locked AR.
      do_reset();
      m_awready = 1'b1;
      aw_req(0, 4'h1, 16'h2000);
      aw_req(1, 4'h2, 16'h2100);
      run_traffic(5, n);
      m_arready = 1'b1;
      ar_req(1, 4'hB);
      @(negedge clk);
      check("ar_first", {m_arvalid, m_arid}, {1'b1, 6'h1B});
      @(posedge clk); #1;
      s_arvalid[1] = 1'b0;
      m_arready = 1'b0;
      ar_req(0, 4'h7);
      ar_req(3, 4'hC);
      @(negedge clk);
      check("ar_locked", {m_arvalid, m_arid}, {1'b1, 6'h3C});
      @(posedge clk); #1;
      rst = 1'b1;
      s_wvalid[0] = 1'b1; s_awvalid[2] = 1'b1; m_wready = 1'b1;
      m_bvalid = 1'b1; m_bid = 6'h01; m_rvalid = 1'b1; m_rid = 6'h01; s_bready = 4'hF; s_rready = 4'hF;
      @(negedge clk);
      check("mid_rst_mvalids", {m_awvalid, m_arvalid, m_wvalid}, 0);
      check("mid_rst_sreadies", {s_awready, s_arready, s_wready}, 0);
      check("mid_rst_svalids", {s_bvalid, s_rvalid}, 0);
      check("mid_rst_mreadies", {m_bready, m_rready}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      s_awvalid = '0;
      m_arready = 1'b1;
      @(negedge clk);
      check("post_rst_ar", {m_arvalid, m_arid}, {1'b1, 6'h07});
      check("post_rst_fifo_empty", {m_wvalid, s_wready}, 0);
      @(posedge clk); #1;
      clear_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
